// File: rtl/sonar_scheduler.sv
// Round-robin owner of a single ultrasonic ranging driver shared by NUM_SENSORS sensors.
// Pings one sensor at a time, keeps each sensor's last distance, and waits a guard gap between pings.
module sonar_scheduler #(
    parameter int NUM_SENSORS    = 4,
    parameter int SEL_W          = 2,
    parameter int TIMEOUT_CYCLES = 2_000_000,
    parameter int GUARD_CYCLES   = 3_000_000,
    parameter int NEAR_CM        = 30
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_enable,
    input  logic                     i_start,
    input  logic [NUM_SENSORS-1:0]   i_sensor_mask,
    input  logic                     i_drv_busy,
    input  logic [7:0]               i_drv_distance,
    output logic                     o_drv_measure,
    output logic [SEL_W-1:0]         o_drv_sel,
    output logic                     o_drv_abort,
    output logic [8*NUM_SENSORS-1:0] o_dist_bus,
    output logic [NUM_SENSORS-1:0]   o_valid_mask,
    output logic [NUM_SENSORS-1:0]   o_timeout_mask,
    output logic [NUM_SENSORS-1:0]   o_near_mask,
    output logic                     o_any_near,
    output logic                     o_sweep_done,
    output logic [2:0]               o_dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_WAIT  = 3'd2,
        S_STORE = 3'd3,
        S_ABORT = 3'd4,
        S_GUARD = 3'd5
    } state_t;

    localparam int MAX_CNT = (TIMEOUT_CYCLES > GUARD_CYCLES) ? TIMEOUT_CYCLES : GUARD_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CNT + 1);
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] GD_LAST = CNT_W'(GUARD_CYCLES - 1);

    state_t                     r_state;
    state_t                     w_state_nxt;
    logic [SEL_W-1:0]           r_cur;
    logic [CNT_W-1:0]           r_cnt;
    logic                       r_busy_seen;
    logic                       r_one_shot;
    logic [8*NUM_SENSORS-1:0]   r_dist;
    logic [NUM_SENSORS-1:0]     r_valid;
    logic [NUM_SENSORS-1:0]     r_timeout;
    logic [NUM_SENSORS-1:0]     r_near;

    logic                       w_load_cur;
    logic [SEL_W-1:0]           w_cur_nxt;
    logic                       w_sweep_done;
    logic                       w_any_mask;
    logic [SEL_W-1:0]           w_lowest;
    logic                       w_has_above;
    logic [SEL_W-1:0]           w_above;

    assign w_any_mask = |i_sensor_mask;

    // Lowest enabled sensor overall, and lowest enabled sensor strictly above the current one.
    always_comb begin
        w_lowest    = '0;
        w_has_above = 1'b0;
        w_above     = '0;
        for (int i = NUM_SENSORS - 1; i >= 0; i--) begin
            if (i_sensor_mask[i]) begin
                w_lowest = SEL_W'(i);
                if (i > int'(r_cur)) begin
                    w_has_above = 1'b1;
                    w_above     = SEL_W'(i);
                end
            end
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_load_cur   = 1'b0;
        w_cur_nxt    = r_cur;
        w_sweep_done = 1'b0;
        case (r_state)
            S_IDLE: begin
                if ((i_enable || i_start) && w_any_mask) begin
                    w_state_nxt = S_START;
                    w_load_cur  = 1'b1;
                    w_cur_nxt   = w_lowest;
                end
            end
            S_START: w_state_nxt = S_WAIT;
            S_WAIT: begin
                // Timeout wins over a completion seen in the same cycle.
                if (r_cnt == TO_LAST) begin
                    w_state_nxt = S_ABORT;
                end else if (r_busy_seen && !i_drv_busy) begin
                    w_state_nxt = S_STORE;
                end
            end
            S_STORE: w_state_nxt = S_GUARD;
            S_ABORT: w_state_nxt = S_GUARD;
            S_GUARD: begin
                if (r_cnt == GD_LAST) begin
                    if (w_has_above) begin
                        w_state_nxt = S_START;
                        w_load_cur  = 1'b1;
                        w_cur_nxt   = w_above;
                    end else begin
                        w_sweep_done = 1'b1;
                        if (i_enable && !r_one_shot && w_any_mask) begin
                            w_state_nxt = S_START;
                            w_load_cur  = 1'b1;
                            w_cur_nxt   = w_lowest;
                        end else begin
                            w_state_nxt = S_IDLE;
                        end
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // One counter serves both the WAIT timeout and the GUARD gap; it restarts on entry to each.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cur       <= '0;
            r_cnt       <= '0;
            r_busy_seen <= 1'b0;
            r_one_shot  <= 1'b0;
        end else begin
            if (w_load_cur) begin
                r_cur <= w_cur_nxt;
            end
            case (r_state)
                S_WAIT, S_GUARD: r_cnt <= r_cnt + CNT_W'(1);
                default:         r_cnt <= '0;
            endcase
            if (r_state == S_START) begin
                r_busy_seen <= 1'b0;
            end else if (r_state == S_WAIT && i_drv_busy) begin
                r_busy_seen <= 1'b1;
            end
            if (r_state == S_IDLE && w_load_cur) begin
                r_one_shot <= i_start && !i_enable;
            end else if (r_state == S_GUARD && w_state_nxt == S_IDLE) begin
                r_one_shot <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_dist    <= '0;
            r_valid   <= '0;
            r_timeout <= '0;
            r_near    <= '0;
        end else if (r_state == S_STORE) begin
            r_dist[{r_cur, 3'b000} +: 8] <= i_drv_distance;
            r_valid[r_cur]               <= 1'b1;
            r_timeout[r_cur]             <= 1'b0;
            r_near[r_cur]                <= (i_drv_distance != 8'd0) && (i_drv_distance < 8'(NEAR_CM));
        end else if (r_state == S_ABORT) begin
            r_dist[{r_cur, 3'b000} +: 8] <= 8'hFF;
            r_timeout[r_cur]             <= 1'b1;
            r_near[r_cur]                <= 1'b0;
        end
    end

    assign o_drv_measure  = (r_state == S_START);
    assign o_drv_abort    = (r_state == S_ABORT);
    assign o_drv_sel      = r_cur;
    assign o_dist_bus     = r_dist;
    assign o_valid_mask   = r_valid;
    assign o_timeout_mask = r_timeout;
    assign o_near_mask    = r_near;
    assign o_any_near     = |r_near;
    assign o_sweep_done   = w_sweep_done;
    assign o_dbg_state    = r_state;

endmodule
